sensor_scanner: RTL and testbench
=================================

SENSOR_SCANNER -- requirements
Module: sensor_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: cycles each row is driven before its columns are sampled; legal range 3..255.
REQ-002 Parameter STABLE_FRAMES, default 3: consecutive identical frames required before the board output updates; legal range 1..15.
REQ-003 Parameter BTN_CYCLES, default 1000000: cycles the synchronized button must hold a new level before it is accepted; legal range 2..2^24-1.
REQ-004 clock  input  1  single system clock; all state is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-006 row_drive_n  output  8  reed-matrix row strobes, active-low, at most one bit low.
REQ-007 col_sense  input  8  matrix column returns, asynchronous, 1 = piece present.
REQ-008 button_raw  input  1  pushbutton, asynchronous, 1 = pressed.
REQ-009 sensorBoard  output  32  debounced occupancy of the 32 dark squares; feeds the sensor-board register input.
REQ-010 buttonPress  output  1  debounced button level; feeds the button-press register input.
REQ-011 btn_pulse  output  1  one-cycle pulse on each accepted press (0->1 of buttonPress).
REQ-012 frame_done  output  1  one-cycle pulse at the end of every full 8-row scan.
REQ-013 board_changed  output  1  one-cycle pulse in the same cycle sensorBoard takes a new value.

Function
REQ-014 col_sense and button_raw shall each pass through a 2-flop synchronizer before any use.
REQ-015 Scan FSM states shall be DRIVE, SAMPLE, COMMIT; row counter r is 0..7.
REQ-016 DRIVE: row_drive_n = ~(1<<r) for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-017 SAMPLE (1 cycle, row still driven): capture the 4 dark-square bits of row r into a shadow frame; if r<7, r <= r+1 and go to DRIVE, else go to COMMIT.
REQ-018 Dark squares: even r uses columns 1,3,5,7; odd r uses columns 0,2,4,6; column c maps to shadow bit 4*r + (c>>1).
REQ-019 COMMIT (1 cycle): row_drive_n = 8'hFF, frame_done = 1, r <= 0, next state DRIVE; frame period = 8*(SETTLE_CYCLES+1)+1 cycles.
REQ-020 COMMIT: if shadow == candidate, stable_cnt <= min(stable_cnt+1, STABLE_FRAMES); else candidate <= shadow and stable_cnt <= 1.
REQ-021 COMMIT: when the resulting stable_cnt == STABLE_FRAMES and the resulting candidate != sensorBoard, sensorBoard <= candidate on that edge and board_changed = 1 in the same cycle.
REQ-022 A change present for the whole of STABLE_FRAMES consecutive frames shall appear on sensorBoard within STABLE_FRAMES+1 frame periods; a single-frame glitch shall never reach sensorBoard when STABLE_FRAMES >= 2.
REQ-023 Button: counter clears whenever the synchronized level equals buttonPress; otherwise it increments, and at BTN_CYCLES buttonPress <= synchronized level and the counter clears.
REQ-024 btn_pulse = 1 for exactly the cycle after buttonPress rises; no pulse on release.
REQ-025 Button and scan logic shall be fully independent; simultaneous events each behave as specified alone.

Reset
REQ-026 While reset = 0: row_drive_n = 8'hFF, sensorBoard = 0, buttonPress = 0, btn_pulse = frame_done = board_changed = 0, candidate = 0, stable_cnt = 0, r = 0, button counter = 0, synchronizers = 0.
REQ-027 The first rising edge after reset releases shall enter DRIVE with r = 0, driving row_drive_n = 8'hFE.
REQ-028 Reset asserted mid-scan shall discard the partial shadow frame; no partial frame may ever reach sensorBoard.

Verification (SETTLE_CYCLES=4, STABLE_FRAMES=3, BTN_CYCLES=8; frame = 41 cycles)
REQ-029 Release reset, col_sense=0 -> row_drive_n steps FE,FD,FB,...,7F (5 cycles each), FF for 1 cycle, frame_done every 41 cycles, sensorBoard stays 0.
REQ-030 Piece at row 2 col 3 held steady -> sensorBoard = 32'h00000200 with one board_changed pulse at the third COMMIT; col 2 of row 2 alone -> sensorBoard stays 0.
REQ-031 Piece present for exactly one frame, then removed -> sensorBoard never leaves 0, no board_changed.
REQ-032 button_raw 1 for 5 cycles -> no change; held 1 for 20 cycles -> buttonPress rises 10 cycles after the raw edge (2 sync + 8), one btn_pulse; release held 20 cycles -> buttonPress falls, no pulse.
REQ-033 Reset pulsed low during row 5 with pieces present -> all outputs 0 immediately; after release the scan restarts at row 0 and sensorBoard updates only after 3 full new frames.
REQ-034 Full board (col_sense = 8'hFF) -> sensorBoard = 32'hFFFFFFFF after 3 frames; then col_sense = 0 -> returns to 0 with one board_changed pulse, 3 frames later.

Source files
------------

// File: rtl/sensor_scanner.sv
// ---------------------------------------------------------------------------
// sensor_scanner
//
// Scans an 8x8 reed-switch matrix one row at a time, extracts the 32 dark
// squares into a shadow frame, and only publishes a frame on sensorBoard once
// the same frame has been seen STABLE_FRAMES times in a row. A separate
// pushbutton debouncer produces a clean level and a press pulse.
//
// Parameters
//   SETTLE_CYCLES  cycles each row is driven before sampling (3..255)
//   STABLE_FRAMES  identical frames needed before sensorBoard updates (1..15)
//   BTN_CYCLES     cycles the button must hold a new level (2..2^24-1)
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low; clears all state
//   row_drive_n    [7:0] row strobes, active-low, at most one bit low
//   col_sense      [7:0] column returns, asynchronous, 1 = piece present
//   button_raw     pushbutton, asynchronous, 1 = pressed
//   sensorBoard    [31:0] debounced occupancy of the dark squares
//   buttonPress    debounced button level
//   btn_pulse      one-cycle pulse on each accepted press
//   frame_done     one-cycle pulse at the end of each full 8-row scan
//   board_changed  one-cycle pulse in the cycle sensorBoard is loaded
// ---------------------------------------------------------------------------
module sensor_scanner #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_FRAMES = 3,
  parameter int BTN_CYCLES    = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  row_drive_n,
  input  logic [7:0]  col_sense,
  input  logic        button_raw,
  output logic [31:0] sensorBoard,
  output logic        buttonPress,
  output logic        btn_pulse,
  output logic        frame_done,
  output logic        board_changed
);

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  STABLE_MAX  = 4'(STABLE_FRAMES);
  localparam logic [23:0] BTN_LAST    = 24'(BTN_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Input synchronizers
  // -------------------------------------------------------------------------
  logic [7:0] col_s1_reg, col_s2_reg;
  logic       btn_s1_reg, btn_s2_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_s1_reg <= 8'h00;
      col_s2_reg <= 8'h00;
      btn_s1_reg <= 1'b0;
      btn_s2_reg <= 1'b0;
    end else begin
      col_s1_reg <= col_sense;
      col_s2_reg <= col_s1_reg;
      btn_s1_reg <= button_raw;
      btn_s2_reg <= btn_s1_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM
  // -------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [2:0] row_reg, row_next;
  logic [7:0] settle_reg, settle_next;
  // Low while in reset and for no cycles after: the first edge after release
  // sets it, so that edge is the one that starts driving row 0. Without it the
  // reset cycle itself would count as the first settle cycle of row 0.
  logic       running_reg;
  logic       sample_en;
  logic       commit_en;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= DRIVE;
      row_reg     <= 3'd0;
      settle_reg  <= 8'd0;
      running_reg <= 1'b0;
    end else begin
      running_reg <= 1'b1;
      if (running_reg) begin
        state_reg  <= state_next;
        row_reg    <= row_next;
        settle_reg <= settle_next;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    settle_next = settle_reg;
    case (state_reg)
      DRIVE: begin
        if (settle_reg == SETTLE_LAST) begin
          settle_next = 8'd0;
          state_next  = SAMPLE;
        end else begin
          settle_next = settle_reg + 8'd1;
        end
      end
      SAMPLE: begin
        if (row_reg == 3'd7) begin
          state_next = COMMIT;
        end else begin
          row_next   = row_reg + 3'd1;
          state_next = DRIVE;
        end
      end
      COMMIT: begin
        row_next   = 3'd0;
        state_next = DRIVE;
      end
      default: begin
        row_next    = 3'd0;
        settle_next = 8'd0;
        state_next  = DRIVE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    row_drive_n = 8'hFF;
    frame_done  = 1'b0;
    sample_en   = 1'b0;
    commit_en   = 1'b0;
    if (running_reg) begin
      case (state_reg)
        DRIVE: begin
          row_drive_n = ~(8'h01 << row_reg);
        end
        SAMPLE: begin
          // Row stays driven during the sample cycle so the sampled
          // columns still belong to this row.
          row_drive_n = ~(8'h01 << row_reg);
          sample_en   = 1'b1;
        end
        COMMIT: begin
          frame_done = 1'b1;
          commit_en  = 1'b1;
        end
        default: begin
          row_drive_n = 8'hFF;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Shadow frame capture
  // -------------------------------------------------------------------------
  // Dark squares alternate by row: even rows use the odd columns, odd rows
  // the even columns. Column c lands on bit (c>>1) of the row's nibble.
  logic [3:0]  dark_bits;
  logic [31:0] shadow_reg;

  always_comb begin
    if (row_reg[0]) begin
      dark_bits = {col_s2_reg[6], col_s2_reg[4], col_s2_reg[2], col_s2_reg[0]};
    end else begin
      dark_bits = {col_s2_reg[7], col_s2_reg[5], col_s2_reg[3], col_s2_reg[1]};
    end
  end

  // Cleared on reset so an interrupted scan can never leak into a commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_reg <= 32'h0000_0000;
    end else if (sample_en) begin
      shadow_reg[{row_reg, 2'b00} +: 4] <= dark_bits;
    end
  end

  // -------------------------------------------------------------------------
  // Frame debounce: candidate + consecutive-match count
  // -------------------------------------------------------------------------
  logic [31:0] candidate_reg, candidate_next;
  logic [3:0]  stable_reg, stable_next;
  logic        board_update;

  always_comb begin
    if (shadow_reg == candidate_reg) begin
      candidate_next = candidate_reg;
      stable_next    = (stable_reg >= STABLE_MAX) ? STABLE_MAX : stable_reg + 4'd1;
    end else begin
      candidate_next = shadow_reg;
      stable_next    = 4'd1;
    end
    // Decision uses the post-commit values so a frame that just reached the
    // threshold is published on the same edge.
    board_update = (stable_next == STABLE_MAX) && (candidate_next != sensorBoard);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      candidate_reg <= 32'h0000_0000;
      stable_reg    <= 4'd0;
      sensorBoard   <= 32'h0000_0000;
    end else if (commit_en) begin
      candidate_reg <= candidate_next;
      stable_reg    <= stable_next;
      if (board_update) begin
        sensorBoard <= candidate_next;
      end
    end
  end

  assign board_changed = commit_en && board_update;

  // -------------------------------------------------------------------------
  // Button debounce
  // -------------------------------------------------------------------------
  // The counter only runs while the synchronized level disagrees with the
  // accepted level, so any bounce back restarts the hold time.
  logic [23:0] btn_cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_cnt_reg <= 24'd0;
      buttonPress <= 1'b0;
      btn_pulse   <= 1'b0;
    end else begin
      btn_pulse <= 1'b0;
      if (btn_s2_reg == buttonPress) begin
        btn_cnt_reg <= 24'd0;
      end else if (btn_cnt_reg == BTN_LAST) begin
        btn_cnt_reg <= 24'd0;
        buttonPress <= btn_s2_reg;
        // Pulse only on acceptance of a press, never on release.
        btn_pulse   <= btn_s2_reg;
      end else begin
        btn_cnt_reg <= btn_cnt_reg + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_scanner.sv
// ---------------------------------------------------------------------------
// tb_sensor_scanner
//
// Directed and randomized bench for sensor_scanner with SETTLE_CYCLES=4,
// STABLE_FRAMES=3, BTN_CYCLES=8 (41-cycle frame). A behavioural reed matrix
// feeds col_sense from row_drive_n. The reference model predicts row strobes
// from the frame period, sensorBoard from the history of whole frames, and
// buttonPress from the run length of the delayed raw button level.
// ---------------------------------------------------------------------------
module tb_sensor_scanner;

  localparam int S     = 4;
  localparam int SF    = 3;
  localparam int BTN   = 8;
  localparam int FRAME = 8 * (S + 1) + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  row_drive_n;
  logic [7:0]  col_sense;
  logic        button_raw;
  logic [31:0] sensorBoard;
  logic        buttonPress;
  logic        btn_pulse;
  logic        frame_done;
  logic        board_changed;

  logic [7:0]  matrix [8];

  sensor_scanner #(
    .SETTLE_CYCLES(S),
    .STABLE_FRAMES(SF),
    .BTN_CYCLES(BTN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .row_drive_n(row_drive_n),
    .col_sense(col_sense),
    .button_raw(button_raw),
    .sensorBoard(sensorBoard),
    .buttonPress(buttonPress),
    .btn_pulse(btn_pulse),
    .frame_done(frame_done),
    .board_changed(board_changed)
  );

  always #5 clock = ~clock;

  // Physical matrix: a low row strobe connects that row's switches to the columns.
  always_comb begin
    col_sense = 8'h00;
    for (int r = 0; r < 8; r++) begin
      if (!row_drive_n[r]) col_sense = col_sense | matrix[r];
    end
  end

  int          tests = 0;
  int          fails = 0;
  int          cyc;
  logic [31:0] exp_board;
  logic [31:0] hist [$];
  logic        exp_press;
  logic        p1, p2, last_d;
  int          hold;
  int          obs_chg;
  int          obs_pulse;
  bit          rand_btn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Occupancy of the 32 dark squares for the current matrix contents.
  function automatic logic [31:0] frame_of();
    logic [31:0] f;
    f = 32'h0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if ((c % 2) != (r % 2)) f[4 * r + c / 2] = matrix[r][c];
    return f;
  endfunction

  task automatic set_mat(input logic [63:0] m);
    for (int r = 0; r < 8; r++) matrix[r] = m[8 * r +: 8];
  endtask

  task automatic model_reset();
    cyc = 0;
    hist.delete();
    exp_board = 32'h0;
    exp_press = 1'b0;
    p1 = 1'b0;
    p2 = 1'b0;
    last_d = 1'b0;
    hold = 0;
  endtask

  // One clock: advance the model, compare every output one unit after the edge.
  task automatic tick();
    logic        raw;
    logic        pulse_exp;
    logic        chg;
    logic [7:0]  one8;
    logic [7:0]  exp_row;
    int          pos;
    raw = button_raw;
    @(posedge clock);
    #1;
    cyc++;
    pos = (cyc - 1) % FRAME;

    // Button: the level two edges ago must have persisted BTN edges.
    pulse_exp = 1'b0;
    if (p2 == last_d) hold++;
    else begin
      hold = 1;
      last_d = p2;
    end
    if (p2 != exp_press && hold >= BTN) begin
      exp_press = p2;
      pulse_exp = p2;
    end
    p2 = p1;
    p1 = raw;
    check("buttonPress", 32'(buttonPress), 32'(exp_press));
    check("btn_pulse", 32'(btn_pulse), 32'(pulse_exp));

    // Scan timing from the frame period.
    one8 = 8'h01;
    exp_row = (pos == FRAME - 1) ? 8'hFF : ~(one8 << (pos / (S + 1)));
    check("row_drive_n", 32'(row_drive_n), 32'(exp_row));
    check("frame_done", 32'(frame_done), 32'(pos == FRAME - 1));

    // Board: publish when the last SF whole frames agree and differ from the board.
    chg = 1'b0;
    if (pos == FRAME - 1) begin
      hist.push_back(frame_of());
      if (hist.size() > SF) void'(hist.pop_front());
      chg = (hist.size() == SF);
      foreach (hist[i]) if (hist[i] != hist[0]) chg = 1'b0;
      if (chg && hist[0] == exp_board) chg = 1'b0;
    end
    check("board_changed", 32'(board_changed), 32'(chg));
    check("sensorBoard", sensorBoard, exp_board);
    if (chg) exp_board = hist[0];

    if (board_changed === 1'b1) obs_chg++;
    if (btn_pulse === 1'b1) obs_pulse++;
    if (rand_btn && $urandom_range(0, 15) == 0) button_raw = ~button_raw;
  endtask

  // Apply a matrix at the start of a frame and run n whole frames, ending in
  // the first cycle after the n-th commit (board update visible).
  task automatic run_frames(input logic [63:0] m, input int n);
    int target;
    while (cyc != 0 && (cyc % FRAME) != 1) tick();
    set_mat(m);
    target = (cyc / FRAME + n) * FRAME + 1;
    while (cyc < target) tick();
  endtask

  logic [63:0] pool [3];
  logic [63:0] mat_b, mat_c;
  logic [31:0] fr_c;
  int          base, pbase, lat;

  initial begin
    rand_btn = 1'b0;
    button_raw = 1'b0;
    set_mat(64'h0);
    obs_chg = 0;
    obs_pulse = 0;
    reset = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_row", 32'(row_drive_n), 32'h000000FF);
    check("rst_board", sensorBoard, 32'h0);
    check("rst_press", 32'(buttonPress), 32'h0);
    check("rst_pulse", 32'(btn_pulse), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_changed", 32'(board_changed), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Empty board scans
    run_frames(64'h0, 2);
    check("empty_board", sensorBoard, 32'h0);

    // Light square (row 2 col 2) is never reported
    run_frames(64'h0000_0000_0004_0000, 3);
    check("light_square", sensorBoard, 32'h0);

    // Single-frame glitch never reaches the board
    base = obs_chg;
    run_frames(64'h0000_0000_0008_0000, 1);
    run_frames(64'h0, 3);
    check("glitch_board", sensorBoard, 32'h0);
    check("glitch_pulses", 32'(obs_chg - base), 32'h0);

    // Steady piece at row 2 col 3
    base = obs_chg;
    run_frames(64'h0000_0000_0008_0000, 3);
    check("piece_r2c3", sensorBoard, 32'h00000200);
    check("piece_pulses", 32'(obs_chg - base), 32'h1);

    // Full board, then empty again
    run_frames(64'hFFFF_FFFF_FFFF_FFFF, 3);
    check("full_board", sensorBoard, 32'hFFFFFFFF);
    base = obs_chg;
    run_frames(64'h0, 3);
    check("cleared_board", sensorBoard, 32'h0);
    check("cleared_pulses", 32'(obs_chg - base), 32'h1);

    // Reset in the middle of row 5 with pieces present
    mat_b = {$urandom, $urandom};
    mat_c = {$urandom, $urandom};
    run_frames(mat_b, 3);
    check("pre_reset_board", sensorBoard, frame_of());
    set_mat(mat_c);
    fr_c = frame_of();
    while ((cyc % FRAME) != 28) tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_row", 32'(row_drive_n), 32'h000000FF);
    check("midrst_board", sensorBoard, 32'h0);
    check("midrst_frame_done", 32'(frame_done), 32'h0);
    check("midrst_changed", 32'(board_changed), 32'h0);
    check("midrst_press", 32'(buttonPress), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    run_frames(mat_c, 2);
    check("post_rst_2frames", sensorBoard, 32'h0);
    base = obs_chg;
    run_frames(mat_c, 1);
    check("post_rst_3frames", sensorBoard, fr_c);
    check("post_rst_pulses", 32'(obs_chg - base), 32'(fr_c != 32'h0));

    // Button: short press ignored
    pbase = obs_pulse;
    button_raw = 1'b1;
    repeat (5) tick();
    button_raw = 1'b0;
    repeat (20) tick();
    check("short_press", 32'(buttonPress), 32'h0);
    check("short_pulses", 32'(obs_pulse - pbase), 32'h0);

    // Button: long press accepted after 2 + BTN cycles
    lat = 0;
    button_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lat == 0 && buttonPress === 1'b1) lat = i;
    end
    check("press_latency", 32'(lat), 32'd10);
    check("press_pulses", 32'(obs_pulse - pbase), 32'h1);

    // Button: release, no pulse
    button_raw = 1'b0;
    repeat (20) tick();
    check("release_level", 32'(buttonPress), 32'h0);
    check("release_pulses", 32'(obs_pulse - pbase), 32'h1);

    // Randomized frames with concurrent random button activity
    for (int k = 0; k < 3; k++) pool[k] = {$urandom, $urandom};
    rand_btn = 1'b1;
    for (int seg = 0; seg < 14; seg++) begin
      run_frames(pool[$urandom_range(0, 2)], $urandom_range(1, 4));
    end
    rand_btn = 1'b0;
    button_raw = 1'b0;
    repeat (30) tick();
    check("final_press", 32'(buttonPress), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
